// File: rtl/audio_sample_fetch_pkg.sv
// Shared definitions for the audio sample fetcher: FSM states, sample width
// and the underflow counter saturation helper.
package audio_sample_fetch_pkg;

  localparam int SAMPLE_W = 16;
  localparam logic [7:0] UNDERFLOW_SAT = 8'd255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Increment an 8-bit event counter, sticking at the saturation value.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    logic [7:0] r;
    if (v == UNDERFLOW_SAT) begin
      r = v;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/audio_sample_fetch_if.sv
// Read port between the sample fetcher (master) and the SDRAM arbiter (slave).
// The request holds mem_read/mem_addr until a single-cycle mem_ack, which
// carries the read word in mem_rddata.
interface audio_sample_fetch_if
  import audio_sample_fetch_pkg::*;
#(
  parameter int ADDR_W = 25
);
  logic                mem_read;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_ack;
  logic [SAMPLE_W-1:0] mem_rddata;

  modport master (output mem_read, output mem_addr, input mem_ack, input mem_rddata);
  modport slave  (input mem_read, input mem_addr, output mem_ack, output mem_rddata);
endinterface

// File: rtl/audio_sample_fetch_sample_fifo.sv
// sample_fifo: synchronous word FIFO with the head word visible combinationally,
// an occupancy count and a synchronous flush. DEPTH must be a power of two so
// the pointers wrap naturally.
module sample_fifo
  import audio_sample_fetch_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                push,
  input  logic [SAMPLE_W-1:0] push_data,
  input  logic                pop,
  output logic [SAMPLE_W-1:0] head,
  output logic [CNT_W-1:0]    count,
  output logic                empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [SAMPLE_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [CNT_W-1:0]    count_r;
  logic                do_push_s;
  logic                do_pop_s;

  // Qualify push/pop: never pop empty, never push full unless a pop frees a slot.
  always_comb begin
    do_pop_s  = pop && (count_r != '0);
    do_push_s = push && ((count_r != CNT_W'(DEPTH)) || do_pop_s);
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    if (do_push_s && !flush) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign empty = (count_r == '0);

endmodule

// File: rtl/audio_sample_fetch.sv
// audio_sample_fetch: streams a song's PCM words from SDRAM into a small FIFO
// and hands one sample out per sample_tick. A new read is only issued when the
// FIFO has room for its result, so the buffer can never overflow.
// Optional build macro FETCH_LOOP_EN: at the end of the song the address and
// length are reloaded and fetching continues, so the song loops while play=1.
module audio_sample_fetch
  import audio_sample_fetch_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 25
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init_done,
  input  logic                 play,
  input  logic [ADDR_W-1:0]    song_base,
  input  logic [ADDR_W-1:0]    song_len,
  input  logic                 sample_tick,
  audio_sample_fetch_if.master mem,
  output logic [SAMPLE_W-1:0]  sample_out,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           underflow_cnt
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t              state_r, state_next_s;
  logic [ADDR_W-1:0]   addr_r, addr_next_s;
  logic [ADDR_W-1:0]   remaining_r, rem_next_s;
  logic                mem_read_r, read_next_s;
  logic [SAMPLE_W-1:0] sample_out_r, sample_next_s;
  logic [7:0]          underflow_cnt_r, uf_next_s;
  logic                busy_r, done_r;

  logic                active_s;
  logic                push_s;
  logic                pop_s;
  logic                flush_s;
  logic [SAMPLE_W-1:0] fifo_head_s;
  logic [CNT_W-1:0]    fifo_count_s;
  logic                fifo_empty_s;

  // FIFO control: only an ack to our own outstanding request is pushed, so a
  // stray ack after reset or while idle is dropped; the FIFO is held flushed in IDLE.
  always_comb begin
    active_s = (state_r == ST_FETCH) || (state_r == ST_DRAIN);
    push_s   = active_s && mem_read_r && mem.mem_ack;
    pop_s    = active_s && sample_tick && !fifo_empty_s;
    flush_s  = (state_r == ST_IDLE);
  end

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush_s),
    .push      (push_s),
    .push_data (mem.mem_rddata),
    .pop       (pop_s),
    .head      (fifo_head_s),
    .count     (fifo_count_s),
    .empty     (fifo_empty_s)
  );

  // Next-state and datapath decode. A new request is only raised from a cycle
  // with nothing outstanding, so FIFO count alone bounds count+outstanding.
  always_comb begin
    state_next_s  = state_r;
    addr_next_s   = addr_r;
    rem_next_s    = remaining_r;
    read_next_s   = mem_read_r;
    sample_next_s = sample_out_r;
    uf_next_s     = underflow_cnt_r;
    case (state_r)
      ST_IDLE: begin
        read_next_s   = 1'b0;
        sample_next_s = '0;
        if (play && init_done) begin
          addr_next_s = song_base;
          rem_next_s  = song_len;
          uf_next_s   = 8'd0;
          if (song_len == '0) begin
            state_next_s = ST_DONE;
          end else begin
            state_next_s = ST_FETCH;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_FETCH, ST_DRAIN: begin
        // Playback side: pop the head, or output silence on a starved tick.
        if (sample_tick) begin
          if (!fifo_empty_s) begin
            sample_next_s = fifo_head_s;
          end else if (state_r == ST_FETCH) begin
            sample_next_s = '0;
            uf_next_s     = sat_inc8(underflow_cnt_r);
          end else begin
            sample_next_s = '0;
          end
        end else begin
          sample_next_s = sample_out_r;
        end
        // Fetch side: retire the outstanding read or raise a new one.
        if (push_s) begin
          read_next_s = 1'b0;
          if (remaining_r == ADDR_W'(1)) begin
`ifdef FETCH_LOOP_EN
            addr_next_s = song_base;
            rem_next_s  = song_len;
`else
            addr_next_s  = addr_r + ADDR_W'(1);
            rem_next_s   = '0;
            state_next_s = ST_DRAIN;
`endif
          end else begin
            addr_next_s = addr_r + ADDR_W'(1);
            rem_next_s  = remaining_r - ADDR_W'(1);
          end
        end else if ((state_r == ST_FETCH) && play && !mem_read_r &&
                     (remaining_r != '0) && (fifo_count_s < CNT_W'(FIFO_DEPTH))) begin
          read_next_s = 1'b1;
        end else begin
          read_next_s = mem_read_r;
        end
        if ((state_r == ST_DRAIN) && fifo_empty_s) begin
          state_next_s  = ST_DONE;
          sample_next_s = '0;
        end else begin
          state_next_s = state_next_s;
        end
        // Stop request: let a pending handshake finish before leaving.
        if (!play && (!mem_read_r || push_s)) begin
          state_next_s  = ST_IDLE;
          read_next_s   = 1'b0;
          sample_next_s = '0;
        end else begin
          state_next_s = state_next_s;
        end
      end
      ST_DONE: begin
        read_next_s   = 1'b0;
        sample_next_s = '0;
        if (!play) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: begin
        state_next_s  = ST_IDLE;
        read_next_s   = 1'b0;
        sample_next_s = '0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_r          <= '0;
      remaining_r     <= '0;
      mem_read_r      <= 1'b0;
      sample_out_r    <= '0;
      underflow_cnt_r <= 8'd0;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
    end else begin
      addr_r          <= addr_next_s;
      remaining_r     <= rem_next_s;
      mem_read_r      <= read_next_s;
      sample_out_r    <= sample_next_s;
      underflow_cnt_r <= uf_next_s;
      busy_r          <= (state_next_s != ST_IDLE);
      done_r          <= (state_next_s == ST_DONE);
    end
  end

  assign mem.mem_read  = mem_read_r;
  assign mem.mem_addr  = addr_r;
  assign sample_out    = sample_out_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign underflow_cnt = underflow_cnt_r;

endmodule

// File: tb/tb_audio_sample_fetch.sv
// Directed bench for audio_sample_fetch (FIFO_DEPTH=4). A single-process
// environment steps the clock, plays the SDRAM arbiter and the sample-rate
// strobe, and predicts every ticked sample from the words it has acked.
module tb_audio_sample_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        init_done;
  logic        play;
  logic [24:0] song_base;
  logic [24:0] song_len;
  logic        sample_tick;
  logic [15:0] sample_out;
  logic        busy;
  logic        done;
  logic [7:0]  underflow_cnt;

  audio_sample_fetch_if #(.ADDR_W(25)) bus ();

  audio_sample_fetch #(.FIFO_DEPTH(4), .ADDR_W(25)) dut (
    .clk           (clk),
    .reset         (reset),
    .init_done     (init_done),
    .play          (play),
    .song_base     (song_base),
    .song_len      (song_len),
    .sample_tick   (sample_tick),
    .mem           (bus.master),
    .sample_out    (sample_out),
    .busy          (busy),
    .done          (done),
    .underflow_cnt (underflow_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [24:0] base;
    logic [24:0] len;
    int          ack_delay;
    int          tick_period;
    int          cycles;
    int          exp_acks;
    bit          exp_done;
    int          exp_uf;
  } song_vec_t;

  int n_cmp = 0;
  int n_fail = 0;

  // environment state
  int          tick_period, tick_cnt, ack_delay, wait_cnt;
  int          acks, pops, exp_uf, model_len;
  bit          model_on, pending, force_tick, stray_ack;
  logic [15:0] exp_sample;
  logic [24:0] req_addr;
  logic [15:0] data_q[$];
  logic [24:0] addr_log[$];

  function automatic logic [15:0] word_of(input logic [24:0] a);
    return 16'hA000 | {4'h0, a[11:0]};
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit model_done();
`ifdef FETCH_LOOP_EN
    return 1'b0;
`else
    return (pops == model_len);
`endif
  endfunction

  // One clock step: check last tick's sample, drive tick, answer the bus.
  task automatic cycle();
    bit do_tick;
    @(negedge clk);
    if (pending) begin
      check("sample_out", sample_out, exp_sample);
      pending = 1'b0;
    end
    bus.mem_ack = 1'b0;
    sample_tick = 1'b0;
    do_tick = 1'b0;
    if (force_tick) begin
      do_tick = 1'b1;
      force_tick = 1'b0;
    end else if (tick_period > 0) begin
      tick_cnt++;
      if (tick_cnt >= tick_period) begin
        tick_cnt = 0;
        do_tick = 1'b1;
      end
    end
    if (do_tick) begin
      sample_tick = 1'b1;
      if (model_on) begin
        pending = 1'b1;
        if (model_done()) begin
          exp_sample = 16'h0000;
        end else if (acks > pops) begin
          exp_sample = data_q[pops];
          pops++;
        end else begin
          exp_sample = 16'h0000;
          if (exp_uf < 255) exp_uf++;
        end
      end
    end
    if (stray_ack) begin
      bus.mem_ack = 1'b1;
      bus.mem_rddata = 16'h0BAD;
      stray_ack = 1'b0;
    end else if (bus.mem_read) begin
      if (wait_cnt == 0) req_addr = bus.mem_addr;
      else check("addr_stable", bus.mem_addr, req_addr);
      wait_cnt++;
      if (wait_cnt >= ack_delay) begin
        bus.mem_ack = 1'b1;
        bus.mem_rddata = word_of(bus.mem_addr);
        data_q.push_back(word_of(bus.mem_addr));
        addr_log.push_back(bus.mem_addr);
        acks++;
        wait_cnt = 0;
      end
    end else begin
      wait_cnt = 0;
    end
  endtask

  task automatic start_env(input int ad, input int tp, input int len);
    tick_period = tp;
    tick_cnt = 0;
    ack_delay = ad;
    wait_cnt = 0;
    acks = 0;
    pops = 0;
    exp_uf = 0;
    model_len = len;
    model_on = 1'b1;
    data_q.delete();
    addr_log.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_mem_read"}, bus.mem_read, 0);
    check({tag, "_mem_addr"}, bus.mem_addr, 0);
    check({tag, "_sample_out"}, sample_out, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_underflow"}, underflow_cnt, 0);
  endtask

  // Play one whole song and check addresses, acks, done and underflows.
  task automatic run_song(input song_vec_t v);
    logic [24:0] ea;
    start_env(v.ack_delay, v.tick_period, int'(v.len));
    song_base = v.base;
    song_len = v.len;
    play = 1'b1;
    repeat (v.cycles) cycle();
    tick_period = 0;
    cycle();
    cycle();
    check("acks", acks, v.exp_acks);
    for (int i = 0; i < addr_log.size() && i < v.exp_acks; i++) begin
      ea = v.base + 25'(i);
      check("read_addr", addr_log[i], ea);
    end
    check("done", done, v.exp_done);
    check("busy_in_done", busy, 1);
    check("underflow_cnt", underflow_cnt, v.exp_uf);
    check("model_underflow", underflow_cnt, exp_uf);
    play = 1'b0;
    model_on = 1'b0;
    cycle();
    cycle();
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
  endtask

  task automatic wait_req(output bit got);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      cycle();
      if (bus.mem_read) got = 1'b1;
    end
    check("req_seen", got, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    song_vec_t vecs[6];
    song_vec_t tail;
    bit got;
    vecs[0] = '{25'h100,     25'd4, 1,  20, 120, 4, 1'b1, 0};
    vecs[1] = '{25'h1FFFFFE, 25'd3, 2,  20, 120, 3, 1'b1, 0};
    vecs[2] = '{25'h2000,    25'd1, 1,  10, 40,  1, 1'b1, 0};
    vecs[3] = '{25'h40,      25'd0, 1,  10, 30,  0, 1'b1, 0};
    vecs[4] = '{25'h3000,    25'd9, 1,  20, 220, 9, 1'b1, 0};
    vecs[5] = '{25'h500,     25'd3, 30, 5,  150, 3, 1'b1, 16};
    tail    = '{25'hB00,     25'd1, 1,  10, 40,  1, 1'b1, 0};

    reset = 1'b1;
    init_done = 1'b0;
    play = 1'b0;
    sample_tick = 1'b0;
    song_base = '0;
    song_len = '0;
    bus.mem_ack = 1'b0;
    bus.mem_rddata = 16'h0000;
    tick_period = 0;
    tick_cnt = 0;
    model_on = 1'b0;
    pending = 1'b0;
    force_tick = 1'b0;
    stray_ack = 1'b0;
    wait_cnt = 0;
    acks = 0;
    repeat (3) cycle();
    check_reset_vals("in_reset");
    reset = 1'b0;
    cycle();
    check_reset_vals("post_reset");

    // play is ignored until the preload is complete
    song_base = 25'h100;
    song_len = 25'd4;
    play = 1'b1;
    repeat (4) cycle();
    check("init_gate_busy", busy, 0);
    check("init_gate_read", bus.mem_read, 0);
    play = 1'b0;
    init_done = 1'b1;
    cycle();

`ifndef FETCH_LOOP_EN
    for (int i = 0; i < 6; i++) run_song(vecs[i]);
`endif

    // FIFO limit: 4 words and no ticks -> fetching stalls until one tick
    start_env(1, 0, 10);
    song_base = 25'h800;
    song_len = 25'd10;
    play = 1'b1;
    repeat (40) cycle();
    check("full_acks", acks, 4);
    check("full_no_read", bus.mem_read, 0);
    force_tick = 1'b1;
    repeat (10) cycle();
    check("refill_acks", acks, 5);
    check("refill_no_read", bus.mem_read, 0);
    check("refill_addr", addr_log[4], 25'h804);
    play = 1'b0;
    model_on = 1'b0;
    cycle();
    cycle();
    check("stop_idle", busy, 0);

    // play dropped with a request outstanding: finish it, then go idle
    start_env(4, 0, 8);
    model_on = 1'b0;
    song_base = 25'h900;
    song_len = 25'd8;
    play = 1'b1;
    wait_req(got);
    play = 1'b0;
    cycle();
    check("drop_busy_hold", busy, 1);
    check("drop_read_hold", bus.mem_read, 1);
    repeat (8) cycle();
    check("drop_acks", acks, 1);
    check("drop_busy", busy, 0);
    check("drop_sample", sample_out, 0);
    check("drop_read", bus.mem_read, 0);
    repeat (10) cycle();
    check("drop_no_more", acks, 1);

    // reset in the middle of a request, then a stray ack while idle
    start_env(10, 0, 8);
    model_on = 1'b0;
    song_base = 25'hA00;
    song_len = 25'd8;
    play = 1'b1;
    wait_req(got);
    repeat (3) cycle();
    reset = 1'b1;
    cycle();
    check_reset_vals("mid_reset");
    play = 1'b0;
    reset = 1'b0;
    stray_ack = 1'b1;
    cycle();
    cycle();
    check("stray_read", bus.mem_read, 0);
    check("stray_busy", busy, 0);
    check("stray_sample", sample_out, 0);
`ifndef FETCH_LOOP_EN
    run_song(tail);
`endif

`ifdef FETCH_LOOP_EN
    // looping song: addresses alternate base, base+1 and done never rises
    start_env(1, 10, 2);
    song_base = 25'hC00;
    song_len = 25'd2;
    play = 1'b1;
    repeat (60) cycle();
    check("loop_done", done, 0);
    check("loop_busy", busy, 1);
    check("loop_enough_acks", (acks >= 6) ? 1 : 0, 1);
    for (int i = 0; i < addr_log.size(); i++) begin
      check("loop_addr", addr_log[i], 25'hC00 + 25'(i % 2));
    end
    tick_period = 0;
    cycle();
    cycle();
    play = 1'b0;
    model_on = 1'b0;
    repeat (4) cycle();
    check("loop_stop", busy, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
